// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one word-aligned bus transfer per request, with byte enables,
// a bounded wait-state timeout, misalignment rejection and aligned/extended load return.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_MEM_RE,
  input  logic        i_MEM_WE,
  input  logic [1:0]  i_HB,
  input  logic        i_ULOAD,
  input  logic [31:0] i_ADDR,
  input  logic [31:0] i_WDATA,
  output logic [31:0] o_RDATA,
  output logic        o_STALL,
  output logic        o_MISALIGNED,
  output logic        o_BUS_ERR,
  output logic        o_BUS_REQ,
  output logic        o_BUS_WE,
  output logic [31:0] o_BUS_ADDR,
  output logic [31:0] o_BUS_WDATA,
  output logic [3:0]  o_BUS_BE,
  input  logic        i_BUS_ACK,
  input  logic [31:0] i_BUS_RDATA
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  hb_q, hb_d;
  logic        uload_q, uload_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;

  logic        req, mis, launch, timeout_hit;
  logic        size_half, size_word;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign req         = i_MEM_WE | i_MEM_RE;
  assign size_half   = (i_HB == 2'b01);
  assign size_word   = i_HB[1];
  assign mis         = req & ((size_half & i_ADDR[0]) | (size_word & (i_ADDR[1:0] != 2'b00)));
  assign launch      = (state_q == StIdle) & req & ~mis;
  assign timeout_hit = (cnt_q == TmoLast);
  assign o_STALL     = ~i_RST & (launch | (state_q == StAccess));

  // Byte enables and lane-replicated store data for the request being launched
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = i_WDATA;
    case (i_HB)
      2'b00: begin
        be_new    = 4'b0001 << i_ADDR[1:0];
        wdata_new = {4{i_WDATA[7:0]}};
      end
      2'b01: begin
        be_new    = i_ADDR[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{i_WDATA[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = i_WDATA;
      end
    endcase
  end

  // Load extraction uses the size/lane captured at launch, not the live inputs
  always_comb begin
    byte_sel = 8'h00;
    unique case (lane_q)
      2'd0: byte_sel = i_BUS_RDATA[7:0];
      2'd1: byte_sel = i_BUS_RDATA[15:8];
      2'd2: byte_sel = i_BUS_RDATA[23:16];
      2'd3: byte_sel = i_BUS_RDATA[31:24];
    endcase
    half_sel = lane_q[1] ? i_BUS_RDATA[31:16] : i_BUS_RDATA[15:0];
    case (hb_q)
      2'b00:   load_ext = uload_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = uload_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = i_BUS_RDATA;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    hb_d        = hb_q;
    uload_d     = uload_q;
    rdata_d     = rdata_q;
    mis_d       = 1'b0;
    err_d       = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;

    case (state_q)
      StIdle: begin
        mis_d = mis;
        if (launch) begin
          state_d     = StAccess;
          cnt_d       = 16'h0000;
          bus_req_d   = 1'b1;
          bus_we_d    = i_MEM_WE;
          bus_addr_d  = {i_ADDR[31:2], 2'b00};
          bus_wdata_d = wdata_new;
          bus_be_d    = be_new;
          lane_d      = i_ADDR[1:0];
          hb_d        = i_HB;
          uload_d     = i_ULOAD;
        end
      end
      StAccess: begin
        // Ack takes precedence over a timeout landing in the same cycle
        if (i_BUS_ACK) begin
          state_d   = StDone;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            rdata_d = load_ext;
          end
        end else if (timeout_hit) begin
          state_d   = StDone;
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          rdata_d   = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // The request still visible here belongs to the completing instruction
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= StIdle;
      cnt_q       <= 16'h0000;
      lane_q      <= 2'b00;
      hb_q        <= 2'b00;
      uload_q     <= 1'b0;
      rdata_q     <= 32'h0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      hb_q        <= hb_d;
      uload_q     <= uload_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  assign o_RDATA      = rdata_q;
  assign o_MISALIGNED = mis_q;
  assign o_BUS_ERR    = err_q;
  assign o_BUS_REQ    = bus_req_q;
  assign o_BUS_WE     = bus_we_q;
  assign o_BUS_ADDR   = bus_addr_q;
  assign o_BUS_WDATA  = bus_wdata_q;
  assign o_BUS_BE     = bus_be_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: transaction-level model drives per-cycle expectations,
// one negedge compare process checks them, plus literal pins on key results.
module tb_lsu_mem_stage;

  localparam int unsigned Tmo = 4;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic        i_MEM_RE, i_MEM_WE, i_ULOAD, i_BUS_ACK;
  logic [1:0]  i_HB;
  logic [31:0] i_ADDR, i_WDATA, i_BUS_RDATA;
  logic [31:0] o_RDATA, o_BUS_ADDR, o_BUS_WDATA;
  logic        o_STALL, o_MISALIGNED, o_BUS_ERR, o_BUS_REQ, o_BUS_WE;
  logic [3:0]  o_BUS_BE;

  always #5 i_CLK = ~i_CLK;

  lsu_mem_stage #(.TIMEOUT(Tmo)) dut (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_MEM_RE    (i_MEM_RE),
    .i_MEM_WE    (i_MEM_WE),
    .i_HB        (i_HB),
    .i_ULOAD     (i_ULOAD),
    .i_ADDR      (i_ADDR),
    .i_WDATA     (i_WDATA),
    .o_RDATA     (o_RDATA),
    .o_STALL     (o_STALL),
    .o_MISALIGNED(o_MISALIGNED),
    .o_BUS_ERR   (o_BUS_ERR),
    .o_BUS_REQ   (o_BUS_REQ),
    .o_BUS_WE    (o_BUS_WE),
    .o_BUS_ADDR  (o_BUS_ADDR),
    .o_BUS_WDATA (o_BUS_WDATA),
    .o_BUS_BE    (o_BUS_BE),
    .i_BUS_ACK   (i_BUS_ACK),
    .i_BUS_RDATA (i_BUS_RDATA)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_we, e_mis, e_err;
  logic [31:0] e_addr, e_wdata, rdata_m;
  logic [3:0]  e_be;

  // Literal pins for the next run_access call
  logic        lit_en = 1'b0;
  logic [31:0] lit_addr, lit_wdata, lit_rdata;
  logic [3:0]  lit_be;
  int          lit_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] be_of(input logic [1:0] hb, input logic [31:0] a);
    logic [3:0] one;
    one = 4'b0001;
    if (hb == 2'b00) return one << a[1:0];
    if (hb == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] lanes_of(input logic [1:0] hb, input logic [31:0] wd);
    if (hb == 2'b00) return {4{wd[7:0]}};
    if (hb == 2'b01) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] hb, input logic ul,
                                          input logic [31:0] a, input logic [31:0] w);
    logic [31:0] t;
    if (hb[1]) return w;
    t = w >> (8 * a[1:0]);
    if (hb == 2'b00) return ul ? {24'h0, t[7:0]} : {{24{t[7]}}, t[7:0]};
    return ul ? {16'h0, t[15:0]} : {{16{t[15]}}, t[15:0]};
  endfunction

  always @(negedge i_CLK) begin
    if (chk_en) begin
      check("stall", 32'(o_STALL), 32'(e_stall));
      check("bus_req", 32'(o_BUS_REQ), 32'(e_req));
      check("misaligned", 32'(o_MISALIGNED), 32'(e_mis));
      check("bus_err", 32'(o_BUS_ERR), 32'(e_err));
      check("rdata", o_RDATA, rdata_m);
      if (e_req) begin
        check("bus_we", 32'(o_BUS_WE), 32'(e_we));
        check("bus_addr", o_BUS_ADDR, e_addr);
        check("bus_wdata", o_BUS_WDATA, e_wdata);
        check("bus_be", 32'(o_BUS_BE), 32'(e_be));
      end
    end
  end

  task automatic step();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic quiet_exp();
    e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_err = 1'b0;
  endtask

  task automatic drive(input logic we, input logic re, input logic [1:0] hb, input logic ul,
                       input logic [31:0] a, input logic [31:0] wd);
    i_MEM_WE = we; i_MEM_RE = re; i_HB = hb; i_ULOAD = ul; i_ADDR = a; i_WDATA = wd;
  endtask

  task automatic run_access(input logic we, input logic re, input logic [1:0] hb, input logic ul,
                            input logic [31:0] a, input logic [31:0] wd, input int waits,
                            input logic [31:0] rword, input bit no_ack);
    int n_acc;
    int stall_seen;
    logic ack;
    n_acc = no_ack ? int'(Tmo) : waits + 1;
    stall_seen = 0;
    step();
    drive(we, re, hb, ul, a, wd);
    i_BUS_ACK = 1'b0; i_BUS_RDATA = $urandom;
    quiet_exp(); e_stall = 1'b1;
    @(negedge i_CLK); stall_seen += int'(o_STALL);
    for (int i = 0; i < n_acc; i++) begin
      step();
      ack = !no_ack && (i == waits);
      i_BUS_ACK = ack;
      i_BUS_RDATA = ack ? rword : $urandom;
      e_stall = 1'b1; e_req = 1'b1; e_we = we;
      e_addr = {a[31:2], 2'b00}; e_wdata = lanes_of(hb, wd); e_be = be_of(hb, a);
      @(negedge i_CLK); stall_seen += int'(o_STALL);
      if (lit_en && i == 0) begin
        check("lit_addr", o_BUS_ADDR, lit_addr);
        check("lit_be", 32'(o_BUS_BE), 32'(lit_be));
        if (we) check("lit_wdata", o_BUS_WDATA, lit_wdata);
      end
    end
    step();
    i_BUS_ACK = 1'b0; i_BUS_RDATA = $urandom;
    quiet_exp(); e_err = no_ack;
    if (no_ack) rdata_m = 32'h0;
    else if (!we) rdata_m = extract(hb, ul, a, rword);
    @(negedge i_CLK); stall_seen += int'(o_STALL);
    if (lit_en) begin
      check("lit_rdata", o_RDATA, lit_rdata);
      check("lit_stall_cycles", 32'(stall_seen), 32'(lit_stall));
    end
    // Upstream advances; a stray ack with garbage data must be ignored
    step();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    i_BUS_ACK = 1'b1; i_BUS_RDATA = $urandom;
    quiet_exp();
    lit_en = 1'b0;
  endtask

  task automatic run_mis(input logic we, input logic re, input logic [1:0] hb,
                         input logic [31:0] a);
    step();
    drive(we, re, hb, 1'b0, a, 32'h5555_AAAA);
    i_BUS_ACK = 1'b0;
    quiet_exp();
    step();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    e_mis = 1'b1;
    @(negedge i_CLK);
    check("lit_mis_pulse", 32'(o_MISALIGNED), 32'h1);
    step();
    e_mis = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    i_RST = 1'b1; i_BUS_ACK = 1'b0; i_BUS_RDATA = 32'h0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rdata_m = 32'h0; e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0;
    quiet_exp();

    // Reset state, with an aligned request present while reset is high
    step();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
    chk_en = 1'b1;
    @(negedge i_CLK);
    check("rst_bus_addr", o_BUS_ADDR, 32'h0);
    check("rst_bus_wdata", o_BUS_WDATA, 32'h0);
    check("rst_bus_be", 32'(o_BUS_BE), 32'h0);
    check("rst_bus_we", 32'(o_BUS_WE), 32'h0);
    step();
    i_RST = 1'b0;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    // Word load, zero wait
    lit_en = 1'b1; lit_addr = 32'h100; lit_be = 4'b1111; lit_rdata = 32'hDEAD_BEEF; lit_stall = 2;
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);

    // Signed then unsigned byte load from lane 3
    lit_en = 1'b1; lit_addr = 32'h100; lit_be = 4'b1000; lit_rdata = 32'hFFFF_FF80; lit_stall = 2;
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_0000, 1'b0);
    lit_en = 1'b1; lit_addr = 32'h100; lit_be = 4'b1000; lit_rdata = 32'h0000_0080; lit_stall = 2;
    run_access(1'b0, 1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_0000, 1'b0);

    // Halfword store, 3 wait states (ack coincides with the timeout boundary)
    lit_en = 1'b1; lit_addr = 32'h20; lit_be = 4'b1100; lit_wdata = 32'hABCD_ABCD;
    lit_rdata = 32'h0000_0080; lit_stall = 5;
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h1234_ABCD, 3, 32'h0, 1'b0);

    // Misaligned word and halfword
    run_mis(1'b0, 1'b1, 2'b10, 32'h101);
    run_mis(1'b1, 1'b0, 2'b01, 32'h43);

    // Assorted aligned accesses
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 1, 32'h8001_7777, 1'b0);
    run_access(1'b0, 1'b1, 2'b01, 1'b1, 32'h200, 32'h0, 0, 32'h1111_FFFE, 1'b0);
    lit_en = 1'b1; lit_addr = 32'h40; lit_be = 4'b0010; lit_wdata = 32'h5A5A_5A5A;
    lit_rdata = 32'h0000_FFFE; lit_stall = 3;
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0000_005A, 1, 32'h0, 1'b0);
    run_access(1'b0, 1'b1, 2'b11, 1'b1, 32'h300, 32'h0, 2, 32'h9234_5678, 1'b0);
    // Store wins when both requests are high
    run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h304, 32'hCAFE_F00D, 0, 32'h0, 1'b0);

    // Timeout: no ack, stray ack afterwards
    lit_en = 1'b1; lit_addr = 32'h400; lit_be = 4'b1111; lit_rdata = 32'h0; lit_stall = 5;
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h0, 0, 32'h0, 1'b1);
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h501, 32'h0, 0, 32'h0000_7F00, 1'b0);

    // Reset asserted in the second ACCESS cycle
    step();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h600, 32'h0);
    i_BUS_ACK = 1'b0;
    quiet_exp(); e_stall = 1'b1;
    step();
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h600; e_be = 4'b1111; e_wdata = 32'h0;
    step();
    i_RST = 1'b1; e_stall = 1'b0;
    step();
    i_RST = 1'b0;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    i_BUS_ACK = 1'b1; i_BUS_RDATA = 32'hFFFF_FFFF;
    quiet_exp(); rdata_m = 32'h0;
    @(negedge i_CLK);
    check("rstmid_bus_addr", o_BUS_ADDR, 32'h0);
    check("rstmid_bus_be", 32'(o_BUS_BE), 32'h0);
    check("rstmid_bus_wdata", o_BUS_WDATA, 32'h0);
    check("rstmid_rdata", o_RDATA, 32'h0);
    lit_en = 1'b1; lit_addr = 32'h600; lit_be = 4'b1111; lit_rdata = 32'h1357_9BDF; lit_stall = 2;
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h600, 32'h0, 0, 32'h1357_9BDF, 1'b0);

    step();
    i_BUS_ACK = 1'b0;
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
